serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
- Serial bit-pattern transmitter: the driving end of the serial `data_in` line that our sequence detectors sample.
- Accepts a parallel pattern word plus a repeat count over a valid/ready handshake.
- Shifts the word out MSB-first, one bit per clock, with a qualifying `data_valid`.
- Optionally repeats the word with zero-filled gaps between copies, so detectors can be stimulated and resynchronised in-system.

Parameters:
- WIDTH, 8: pattern word width in bits (>=2).
- CNT_W, 4: repeat-count field width.
- GAP_LEN, 1: zero bits inserted between repetitions (0 = back-to-back copies).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- load_valid  in  1  pattern word and repeat count are offered.
- load_ready  out  1  block can accept a pattern (high only in IDLE).
- load_data  in  WIDTH  pattern word, transmitted MSB first.
- load_repeat  in  CNT_W  extra repetitions; total copies = load_repeat+1.
- abort  in  1  synchronous cancel of the current transmission.
- data_out  out  1  serial bit.
- data_valid  out  1  data_out carries a pattern or gap bit this cycle.
- busy  out  1  high in SHIFT or GAP.
- done  out  1  single-cycle pulse after the last bit of the last copy.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (reset_n).
- Reset:
  - Sampled on clk when reset_n=0.
  - State goes to IDLE; data_out, data_valid, busy and done are 0.
  - Internal shift register, bit counter and repeat counter are 0.
  - load_ready rises the first cycle after reset_n=1.
  - Reset mid-transmission truncates immediately, with no done pulse.
- All outputs are registered.
- FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - load_ready=1, data_valid=0.
  - Handshake at cycle T (load_valid && load_ready): capture load_data into the shift register and a saved copy; capture load_repeat; bit counter = WIDTH-1; go to SHIFT.
- SHIFT:
  - First bit (load_data[WIDTH-1]) appears on data_out with data_valid=1 at T+1.
  - One bit per cycle; the bit counter decrements.
  - After the LSB, if the repeat counter is 0, go to DONE.
  - Otherwise decrement the repeat counter and reload the shift register from the saved copy.
  - Then go to GAP if GAP_LEN>0, else straight into SHIFT, with the MSB of the next copy driven on the following cycle (no bubble).
- GAP:
  - Drive GAP_LEN cycles of data_out=0, data_valid=1, counted by a gap counter.
  - Then go to SHIFT.
- DONE:
  - One cycle with done=1, data_valid=0, load_ready=0.
  - Then go to IDLE.
- Timing for a repeat count R:
  - Last data bit at cycle T + (R+1)*WIDTH + R*GAP_LEN.
  - done on the next cycle.
  - load_ready one cycle after done.
- Outside valid cycles: data_out=0 whenever data_valid=0.
- busy = SHIFT or GAP.
- abort:
  - Any non-IDLE state goes to IDLE on the next edge.
  - data_valid and busy drop that edge; no done pulse.
  - abort in IDLE is ignored.
  - abort and load_valid together in IDLE: abort has priority and the load is not accepted.
- load_valid while not ready: ignored; no queueing.
- Counter widths:
  - Bit counter is clog2(WIDTH) bits.
  - Gap counter is clog2(GAP_LEN+1) bits.
  - No wrap: counters are reloaded, never underflowed.

Decomposition:
- Shared package seq_pkg:
  - tx_state_t enum (IDLE, SHIFT, GAP, DONE), 2-bit encoding.
  - Default WIDTH/CNT_W/GAP_LEN constants, reused by detector benches.
- No sub-module: FSM, counters and shift register stay in one module.

Test Plan:
- Single copy: load_data=8'hF0, load_repeat=0, handshake at T -> data_out 1,1,1,1,0,0,0,0 at T+1..T+8 with data_valid=1; done=1 at T+9; load_ready=1 at T+10.
- Repeats with gap: 8'hA5, load_repeat=2, GAP_LEN=1 -> A5,0,A5,0,A5 serial over 26 cycles; exactly one done, at T+27.
- No gap: GAP_LEN=0, 8'h0F, repeat=1 -> 16 contiguous valid bits 0000111100001111; done at T+17.
- Abort: abort asserted at T+4 during 8'hFF -> data_valid=0 from T+5; no done; load_ready=1 at T+5; a new load is accepted and transmitted correctly.
- Reset mid-stream: reset_n=0 at T+3 -> outputs all 0 next edge; load_ready=1 the cycle after reset_n returns to 1.
- Loopback: drive data_in of a four-consecutive-ones detector from data_out with 8'hF0 -> detector flags exactly once per copy.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the sequence-detector benches.
// Holds the transmitter state encoding, default geometry and a counter-width helper.
package seq_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_GAP   = 2'd2,
    TX_DONE  = 2'd3
  } tx_state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_CNT_W   = 4;
  localparam int DEF_GAP_LEN = 1;

  // clog2 that never returns 0, so a counter always has at least one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: accepts a word plus repeat count, shifts it out MSB first
// with data_valid, optionally separating copies with zero-filled gap bits.
import seq_pkg::*;

module serial_pattern_tx #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int GAP_LEN = DEF_GAP_LEN
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_repeat,
  input  logic             abort,
  output logic             data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int BIT_W = cnt_width(WIDTH);
  localparam int GAP_W = cnt_width(GAP_LEN + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  // Handshake: a word is taken on a rising edge where load_valid && load_ready
  // and abort is low; load_valid while load_ready is low is simply dropped.
  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] saved_q, saved_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             load_ready_q, load_ready_d;
  logic             data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  assign accept = load_valid && load_ready_q && !abort;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      saved_q   <= '0;
      bit_cnt_q <= '0;
      rep_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      saved_q   <= saved_d;
      bit_cnt_q <= bit_cnt_d;
      rep_q     <= rep_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // shift_q[MSB] is always the bit being driven while in SHIFT
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    saved_d   = saved_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;
    gap_cnt_d = gap_cnt_q;
    if (abort && (state_q != TX_IDLE)) begin
      state_d = TX_IDLE;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (accept) begin
            shift_d   = load_data;
            saved_d   = load_data;
            rep_d     = load_repeat;
            bit_cnt_d = BIT_LAST;
            state_d   = TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (bit_cnt_q != '0) begin
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
          end else if (rep_q == '0) begin
            state_d = TX_DONE;
          end else begin
            rep_d     = rep_q - CNT_W'(1);
            shift_d   = saved_q;
            bit_cnt_d = BIT_LAST;
            if (GAP_LEN > 0) begin
              state_d   = TX_GAP;
              gap_cnt_d = GAP_LAST;
            end else begin
              state_d = TX_SHIFT;
            end
          end
        end
        TX_GAP: begin
          if (gap_cnt_q == '0) state_d = TX_SHIFT;
          else gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
        TX_DONE: state_d = TX_IDLE;
        default: state_d = TX_IDLE;
      endcase
    end
  end

  // Outputs are derived from the next state so they register alongside it
  always_comb begin
    load_ready_d = (state_d == TX_IDLE);
    data_valid_d = (state_d == TX_SHIFT) || (state_d == TX_GAP);
    busy_d       = data_valid_d;
    done_d       = (state_d == TX_DONE);
    data_out_d   = (state_d == TX_SHIFT) ? shift_d[WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      load_ready_q <= 1'b0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      load_ready_q <= load_ready_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign load_ready = load_ready_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: one instance with a 1-bit gap, one with back-to-back copies,
// checked against a bit-stream reference built from the word, repeat count and gap length.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       lv_g = 1'b0, lv_ng = 1'b0, abort = 1'b0;
  logic [7:0] ld = '0;
  logic [3:0] lr = '0;

  logic       rdy_g, do_g, dv_g, busy_g, done_g;
  logic       rdy_ng, do_ng, dv_ng, busy_ng, done_ng;
  logic [1:0] st_g, st_ng;

  int sel = 0;
  logic o_rdy, o_do, o_dv, o_busy, o_done;

  int n_total = 0;
  int n_bad   = 0;

  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .CNT_W(4), .GAP_LEN(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .load_valid(lv_g), .load_ready(rdy_g),
    .load_data(ld), .load_repeat(lr), .abort(abort), .data_out(do_g),
    .data_valid(dv_g), .busy(busy_g), .done(done_g), .dbg_state(st_g)
  );

  serial_pattern_tx #(.WIDTH(8), .CNT_W(4), .GAP_LEN(0)) u_dut_ng (
    .clk(clk), .reset_n(reset_n), .load_valid(lv_ng), .load_ready(rdy_ng),
    .load_data(ld), .load_repeat(lr), .abort(abort), .data_out(do_ng),
    .data_valid(dv_ng), .busy(busy_ng), .done(done_ng), .dbg_state(st_ng)
  );

  always_comb begin
    o_rdy  = rdy_g;
    o_do   = do_g;
    o_dv   = dv_g;
    o_busy = busy_g;
    o_done = done_g;
    if (sel != 0) begin
      o_rdy  = rdy_ng;
      o_do   = do_ng;
      o_dv   = dv_ng;
      o_busy = busy_ng;
      o_done = done_ng;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at a negedge with load_ready observed high.
  task automatic wait_ready();
    int i;
    for (i = 0; i < 32; i++) begin
      if (o_rdy) break;
      @(negedge clk);
    end
    if (!o_rdy) check("ready_timeout", 32'(o_rdy), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_dv", 32'(o_dv), 32'd0);
      check("idle_do", 32'(o_do), 32'd0);
      check("idle_done", 32'(o_done), 32'd0);
    end
  endtask

  task automatic handshake(input int s, input logic [7:0] d, input int r);
    sel = s;
    wait_ready();
    ld = d;
    lr = 4'(r);
    if (s != 0) lv_ng = 1'b1;
    else lv_g = 1'b1;
    @(posedge clk);
    #1;
    lv_g  = 1'b0;
    lv_ng = 1'b0;
  endtask

  // Reference: (r+1) copies of d MSB first, gap zeros between copies; done one cycle
  // after the last bit, load_ready one cycle after done. Also counts windows of four
  // consecutive valid ones, as a downstream 1111 detector would see them.
  task automatic run_stream(input int s, input logic [7:0] d, input int r, output int flags);
    int gap;
    logic [3:0] win;
    logic [0:0] e;
    gap = (s != 0) ? 0 : 1;
    exp_q.delete();
    for (int c = 0; c <= r; c++) begin
      for (int b = 7; b >= 0; b--) exp_q.push_back(d[b]);
      if (c < r) for (int g = 0; g < gap; g++) exp_q.push_back(1'b0);
    end
    handshake(s, d, r);
    win   = '0;
    flags = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("stream_dv", 32'(o_dv), 32'd1);
      check("stream_bit", 32'(o_do), 32'(e));
      check("stream_busy", 32'(o_busy), 32'd1);
      check("stream_done_early", 32'(o_done), 32'd0);
      win = {win[2:0], o_do};
      if (win == 4'hF) flags++;
    end
    @(negedge clk);
    check("done_pulse", 32'(o_done), 32'd1);
    check("done_dv", 32'(o_dv), 32'd0);
    check("done_do", 32'(o_do), 32'd0);
    check("done_busy", 32'(o_busy), 32'd0);
    check("done_rdy", 32'(o_rdy), 32'd0);
    @(negedge clk);
    check("post_rdy", 32'(o_rdy), 32'd1);
    check("post_done", 32'(o_done), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int flags;
    logic [7:0] d;
    int r;

    repeat (2) @(negedge clk);
    check("rst_rdy_g", 32'(rdy_g), 32'd0);
    check("rst_dv_g", 32'(dv_g), 32'd0);
    check("rst_do_g", 32'(do_g), 32'd0);
    check("rst_busy_g", 32'(busy_g), 32'd0);
    check("rst_done_g", 32'(done_g), 32'd0);
    check("rst_rdy_ng", 32'(rdy_ng), 32'd0);
    check("rst_dv_ng", 32'(dv_ng), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_rel_rdy_g", 32'(rdy_g), 32'd1);
    check("rst_rel_rdy_ng", 32'(rdy_ng), 32'd1);

    // directed patterns
    run_stream(0, 8'hF0, 0, flags);
    check("single_f0_flags", 32'(flags), 32'd1);
    idle(2);
    run_stream(0, 8'hA5, 2, flags);
    idle(2);
    run_stream(1, 8'h0F, 1, flags);
    idle(2);
    run_stream(0, 8'hF0, 2, flags);
    check("loopback_flags", 32'(flags), 32'd3);
    idle(2);

    // abort mid-stream
    sel = 0;
    handshake(0, 8'hFF, 3);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("abort_pre_bit", 32'(o_do), 32'd1);
      check("abort_pre_dv", 32'(o_dv), 32'd1);
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_dv", 32'(o_dv), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_rdy", 32'(o_rdy), 32'd1);
    check("abort_done", 32'(o_done), 32'd0);
    idle(40);
    run_stream(0, 8'h3C, 1, flags);

    // abort together with load in idle: load must be dropped
    sel = 0;
    wait_ready();
    abort = 1'b1;
    lv_g  = 1'b1;
    ld    = 8'h81;
    @(posedge clk);
    #1;
    abort = 1'b0;
    lv_g  = 1'b0;
    @(negedge clk);
    check("abort_load_dv", 32'(o_dv), 32'd0);
    check("abort_load_busy", 32'(o_busy), 32'd0);
    check("abort_load_rdy", 32'(o_rdy), 32'd1);
    idle(10);

    // reset mid-stream
    handshake(0, 8'hC3, 1);
    @(negedge clk);
    check("rst_mid_b1", 32'(o_do), 32'd1);
    @(negedge clk);
    check("rst_mid_b2", 32'(o_do), 32'd1);
    @(negedge clk);
    check("rst_mid_b3", 32'(o_do), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_do", 32'(o_do), 32'd0);
    check("rst_mid_dv", 32'(o_dv), 32'd0);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    check("rst_mid_done", 32'(o_done), 32'd0);
    check("rst_mid_rdy", 32'(o_rdy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_mid_rel_rdy", 32'(o_rdy), 32'd1);
    idle(20);
    run_stream(0, 8'h5A, 0, flags);

    // randomized traffic on both instances
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      r = $urandom_range(0, 3);
      run_stream($urandom_range(0, 1), d, r, flags);
      idle($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
